// File: rtl/rt_ibex_rw_pkg.sv
// Shared definitions for the register-window spill/fill path: controller states,
// frame geometry and the EABI register offset map also used by the window file.
package rt_ibex_rw_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SPILL_REQ  = 3'd1,
      SPILL_WAIT = 3'd2,
      FILL_REQ   = 3'd3,
      FILL_WAIT  = 3'd4,
      DONE       = 3'd5
   } rw_spill_state_e;

   // Seven EABI registers followed by the saved mcause and mepc.
   localparam int unsigned WordsPerFrame = 9;

   function automatic logic [4:0] eabi_reg_addr(input logic [3:0] idx);
      case (idx)
         4'd0:    return 5'd1;
         4'd1:    return 5'd5;
         4'd2:    return 5'd10;
         4'd3:    return 5'd11;
         4'd4:    return 5'd12;
         4'd5:    return 5'd13;
         4'd6:    return 5'd15;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/rt_ibex_window_spill_unit.sv
// Spill/fill controller: drains the top register window to a memory stack on
// nested interrupt entry when the window file is full, and refills it on return.
module rt_ibex_window_spill_unit
   import rt_ibex_rw_pkg::*;
#(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned WindowSize = 7,
   parameter logic [31:0] SpillBase  = 32'h0000_0000,
   parameter int unsigned SpillDepth = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               nest_req_i,
   input  logic                               unnest_req_i,
   output logic                               ack_o,
   output logic                               busy_o,
   output logic                               err_o,
   output logic [$clog2(SpillDepth+1)-1:0]    spill_depth_o,
   input  logic                               window_full_i,
   output logic                               increment_ptr_o,
   output logic                               decrement_ptr_o,
   output logic [4:0]                         rf_raddr_o,
   input  logic [DataWidth-1:0]               rf_rdata_i,
   output logic [4:0]                         rf_waddr_o,
   output logic [DataWidth-1:0]               rf_wdata_o,
   output logic                               rf_we_o,
   input  logic [31:0]                        aux_mcause_i,
   input  logic [31:0]                        aux_mepc_i,
   output logic [31:0]                        aux_mcause_o,
   output logic [31:0]                        aux_mepc_o,
   output logic                               aux_we_o,
   output logic                               data_req_o,
   input  logic                               data_gnt_i,
   input  logic                               data_rvalid_i,
   input  logic                               data_err_i,
   output logic                               data_we_o,
   output logic [3:0]                         data_be_o,
   output logic [31:0]                        data_addr_o,
   output logic [31:0]                        data_wdata_o,
   input  logic [31:0]                        data_rdata_i
);

   localparam int unsigned DepthW = $clog2(SpillDepth + 1);
   localparam logic [3:0]  LastIdx = 4'(WindowSize + 1);
   localparam logic [3:0]  CauseIdx = 4'(WindowSize);
   localparam logic [31:0] FrameWords = 32'(WindowSize + 2);
   localparam logic [DepthW-1:0] DepthMax = DepthW'(SpillDepth);

   rw_spill_state_e   state_q;
   logic [3:0]        idx_q;
   logic [DepthW-1:0] depth_q;
   logic [31:0]       mcause_q;

   logic              depth_full, nest_go, unnest_go, in_wait, fill_rsp, is_reg;
   logic [DepthW-1:0] frame;
   logic [31:0]       word_off;

   assign depth_full = (depth_q == DepthMax);
   assign nest_go    = (state_q == IDLE) && nest_req_i;
   assign unnest_go  = (state_q == IDLE) && !nest_req_i && unnest_req_i;
   assign in_wait    = (state_q == SPILL_WAIT) || (state_q == FILL_WAIT);
   assign fill_rsp   = (state_q == FILL_WAIT) && data_rvalid_i && !data_err_i;
   assign is_reg     = (idx_q < CauseIdx);

   // A fill reads back the most recently pushed frame, one below the current depth.
   assign frame    = (state_q == FILL_REQ) ? depth_q - DepthW'(1) : depth_q;
   assign word_off = 32'(frame) * FrameWords + 32'(idx_q);

   always_comb begin
      ack_o           = (state_q == DONE);
      busy_o          = (state_q != IDLE) && (state_q != DONE);
      increment_ptr_o = nest_go && !window_full_i;
      decrement_ptr_o = unnest_go && (depth_q == '0);
      err_o           = (nest_go && window_full_i && depth_full) ||
                        (in_wait && data_rvalid_i && data_err_i);
      data_req_o      = (state_q == SPILL_REQ) || (state_q == FILL_REQ);
      data_we_o       = (state_q == SPILL_REQ);
      data_be_o       = 4'hF;
      data_addr_o     = data_req_o ? SpillBase + (word_off << 2) : 32'h0;
      data_wdata_o    = 32'h0;
      rf_raddr_o      = 5'd0;
      if (state_q == SPILL_REQ) begin
         if (is_reg) begin
            rf_raddr_o   = eabi_reg_addr(idx_q);
            data_wdata_o = 32'(rf_rdata_i);
         end else if (idx_q == CauseIdx) begin
            data_wdata_o = aux_mcause_i;
         end else begin
            data_wdata_o = aux_mepc_i;
         end
      end
      rf_we_o      = fill_rsp && is_reg;
      rf_waddr_o   = rf_we_o ? eabi_reg_addr(idx_q) : 5'd0;
      rf_wdata_o   = rf_we_o ? DataWidth'(data_rdata_i) : '0;
      aux_we_o     = fill_rsp && (idx_q == LastIdx);
      aux_mcause_o = aux_we_o ? mcause_q : 32'h0;
      aux_mepc_o   = aux_we_o ? data_rdata_i : 32'h0;
   end

   assign spill_depth_o = depth_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         depth_q  <= '0;
         mcause_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (nest_req_i) begin
                  if (window_full_i && !depth_full) begin
                     idx_q   <= '0;
                     state_q <= SPILL_REQ;
                  end else begin
                     state_q <= DONE;
                  end
               end else if (unnest_req_i) begin
                  if (depth_q != '0) begin
                     idx_q   <= '0;
                     state_q <= FILL_REQ;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            SPILL_REQ: if (data_gnt_i) state_q <= SPILL_WAIT;
            FILL_REQ:  if (data_gnt_i) state_q <= FILL_WAIT;
            SPILL_WAIT: begin
               if (data_rvalid_i) begin
                  if (data_err_i) begin
                     idx_q   <= '0;
                     state_q <= DONE;
                  end else if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     depth_q <= depth_q + DepthW'(1);
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     state_q <= SPILL_REQ;
                  end
               end
            end
            FILL_WAIT: begin
               if (data_rvalid_i) begin
                  if (data_err_i) begin
                     idx_q   <= '0;
                     state_q <= DONE;
                  end else if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     depth_q <= depth_q - DepthW'(1);
                     state_q <= DONE;
                  end else begin
                     // mepc arrives last and is forwarded directly; hold mcause until then.
                     if (idx_q == CauseIdx) mcause_q <= data_rdata_i;
                     idx_q   <= idx_q + 4'd1;
                     state_q <= FILL_REQ;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rt_ibex_window_spill_unit.sv
// Scoreboard bench for the window spill unit: stimulus pushes expected bus,
// register-file, pointer and handshake events; a monitor pops and compares them.
module tb_rt_ibex_window_spill_unit;

   localparam int EV_WR = 1, EV_RD = 2, EV_RFW = 3, EV_AUX = 4;
   localparam int EV_INC = 5, EV_DEC = 6, EV_ERR = 7, EV_ACK = 8;

   typedef struct packed {
      logic [3:0]  kind;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   logic        clk, rst_ni;
   logic        nest_req_i, unnest_req_i, window_full_i;
   logic        ack_o, busy_o, err_o, increment_ptr_o, decrement_ptr_o;
   logic [3:0]  spill_depth_o;
   logic [4:0]  rf_raddr_o, rf_waddr_o;
   logic [31:0] rf_rdata_i, rf_wdata_o;
   logic        rf_we_o, aux_we_o;
   logic [31:0] aux_mcause_i, aux_mepc_i, aux_mcause_o, aux_mepc_o;
   logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

   logic [31:0] rf [32];
   logic [31:0] mem [128];
   logic [31:0] vals [9];
   logic [4:0]  rmap [7];
   ev_t         exp_q [$];
   int          n_vec = 0, n_bad = 0;
   int          gnt_delay = 0, err_idx = 0;
   bit          err_en = 0;

   assign rf_rdata_i = rf[rf_raddr_o];

   rt_ibex_window_spill_unit dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .nest_req_i(nest_req_i), .unnest_req_i(unnest_req_i),
      .ack_o(ack_o), .busy_o(busy_o), .err_o(err_o), .spill_depth_o(spill_depth_o),
      .window_full_i(window_full_i),
      .increment_ptr_o(increment_ptr_o), .decrement_ptr_o(decrement_ptr_o),
      .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
      .aux_mcause_i(aux_mcause_i), .aux_mepc_i(aux_mepc_i),
      .aux_mcause_o(aux_mcause_o), .aux_mepc_o(aux_mepc_o), .aux_we_o(aux_we_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_err_i(data_err_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [95:0] act, input logic [95:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = 4'(kind);
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d a=%0h d=%0h expected none", kind, a, d);
      end else begin
         e = exp_q.pop_front();
         check("event", {28'h0, 4'(kind), a, d}, {28'h0, e.kind, e.a, e.d});
      end
   endtask

   // Bus slave: grants after gnt_delay request cycles, responds the cycle after grant.
   initial begin
      bit   pend;
      bit   pend_we;
      int   pend_word;
      int   wait_cnt;
      pend = 0; pend_we = 0; pend_word = 0; wait_cnt = 0;
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
      forever begin
         @(negedge clk);
         data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
         if (!rst_ni) begin
            pend = 0;
            wait_cnt = 0;
         end else if (pend) begin
            pend = 0;
            data_rvalid_i = 1;
            data_rdata_i = pend_we ? 32'h0 : mem[pend_word];
            if (err_en && (pend_word % 9) == err_idx) data_err_i = 1;
         end else if (data_req_o) begin
            if (wait_cnt >= gnt_delay) begin
               data_gnt_i = 1;
               pend = 1;
               pend_we = data_we_o;
               pend_word = int'(data_addr_o[8:2]);
               if (data_we_o) mem[pend_word] = data_wdata_o;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Monitor: samples 2 time units after the falling edge, well away from the rising edge.
   initial begin
      bit          hold_v;
      logic [65:0] held;
      hold_v = 0;
      held = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_ni) begin
            if (hold_v) check("hold_stable", {30'h0, data_req_o, data_we_o, data_addr_o, data_wdata_o},
                              {30'h0, held});
            hold_v = data_req_o && !data_gnt_i;
            held = {data_req_o, data_we_o, data_addr_o, data_wdata_o};
            if (data_req_o && data_gnt_i) begin
               if (data_we_o) observe(EV_WR, data_addr_o, data_wdata_o);
               else           observe(EV_RD, data_addr_o, 32'h0);
            end
            if (rf_we_o)         observe(EV_RFW, {27'h0, rf_waddr_o}, rf_wdata_o);
            if (aux_we_o)        observe(EV_AUX, aux_mcause_o, aux_mepc_o);
            if (increment_ptr_o) observe(EV_INC, 32'h0, 32'h0);
            if (decrement_ptr_o) observe(EV_DEC, 32'h0, 32'h0);
            if (err_o)           observe(EV_ERR, 32'h0, 32'h0);
            if (ack_o)           observe(EV_ACK, 32'h0, 32'h0);
         end else begin
            hold_v = 0;
         end
      end
   end

   task automatic chk_quiet(input string nm, input int exp_depth);
      check({nm, "_ctl"}, {87'h0, ack_o, busy_o, err_o, increment_ptr_o, decrement_ptr_o,
            rf_we_o, aux_we_o, data_req_o, data_we_o}, 96'h0);
      check({nm, "_data"}, {data_addr_o | data_wdata_o | rf_wdata_o, aux_mcause_o | aux_mepc_o,
            22'h0, rf_raddr_o, rf_waddr_o}, 96'h0);
      check({nm, "_be"}, {92'h0, data_be_o}, 96'hF);
      check({nm, "_depth"}, {92'h0, spill_depth_o}, 96'(exp_depth));
   endtask

   task automatic do_req(input string nm, input bit nest, input bit unnest,
                         input int exp_lat, input int exp_depth);
      int lat;
      lat = -1;
      @(negedge clk);
      nest_req_i = nest;
      unnest_req_i = unnest;
      for (int c = 0; c < 400; c++) begin
         #2;
         if (c == 1) check({nm, "_busy"}, {95'h0, busy_o}, {95'h0, exp_lat > 1});
         if (ack_o) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      nest_req_i = 0;
      unnest_req_i = 0;
      check({nm, "_ack_latency"}, 96'(lat), 96'(exp_lat));
      #1;
      check({nm, "_depth"}, {92'h0, spill_depth_o}, 96'(exp_depth));
      $display("%s: nest=%0d unnest=%0d ack after %0d cycles, depth %0d",
               nm, nest, unnest, lat, spill_depth_o);
   endtask

   task automatic push_spill(input int frame, input int nwords);
      for (int i = 0; i < nwords; i++) push(EV_WR, 32'((frame * 9 + i) * 4), vals[i]);
   endtask

   task automatic push_fill(input int frame);
      for (int i = 0; i < 9; i++) begin
         push(EV_RD, 32'((frame * 9 + i) * 4), 32'h0);
         if (i < 7) push(EV_RFW, {27'h0, rmap[i]}, vals[i]);
      end
      push(EV_AUX, 32'h8000_0007, 32'h0000_0100);
   endtask

   initial begin
      vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77,
               32'h8000_0007, 32'h0000_0100};
      rmap = '{5'd1, 5'd5, 5'd10, 5'd11, 5'd12, 5'd13, 5'd15};
      for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + 32'(i);
      for (int i = 0; i < 7; i++) rf[rmap[i]] = vals[i];
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      aux_mcause_i = 32'h8000_0007;
      aux_mepc_i = 32'h0000_0100;
      nest_req_i = 0; unnest_req_i = 0; window_full_i = 0;
      rst_ni = 0;
      repeat (3) @(negedge clk);
      #2;
      chk_quiet("reset", 0);
      @(negedge clk);
      rst_ni = 1;
      #2;
      chk_quiet("post_reset", 0);

      // Nest into a free window: pointer pulse, then ack, no bus traffic.
      push(EV_INC, 0, 0); push(EV_ACK, 0, 0);
      do_req("nest_free", 1, 0, 1, 0);

      // Nest with full window file: spill frame 0.
      window_full_i = 1;
      push_spill(0, 9); push(EV_ACK, 0, 0);
      do_req("spill_f0", 1, 0, 19, 1);

      // Unnest: refill frame 0, no pointer decrement.
      push_fill(0); push(EV_ACK, 0, 0);
      do_req("fill_f0", 0, 1, 19, 0);

      // Unnest with empty stack: pointer pulse only.
      push(EV_DEC, 0, 0); push(EV_ACK, 0, 0);
      do_req("unnest_empty", 0, 1, 1, 0);

      // Fill the stack; first spill has a 3-cycle grant delay per word.
      for (int f = 0; f < 8; f++) begin
         gnt_delay = (f == 0) ? 3 : 0;
         push_spill(f, 9); push(EV_ACK, 0, 0);
         do_req($sformatf("spill_f%0d", f), 1, 0, (f == 0) ? 46 : 19, f + 1);
      end
      gnt_delay = 0;

      // Overflow: error pulse, no traffic, depth stays at 8.
      push(EV_ERR, 0, 0); push(EV_ACK, 0, 0);
      do_req("overflow", 1, 0, 1, 8);

      // Simultaneous nest and unnest: nest is served.
      window_full_i = 0;
      push(EV_INC, 0, 0); push(EV_ACK, 0, 0);
      do_req("nest_wins", 1, 1, 1, 8);

      // Refill the topmost frame from depth 8.
      window_full_i = 1;
      push_fill(7); push(EV_ACK, 0, 0);
      do_req("fill_f7", 0, 1, 19, 7);

      // Bus error on word 4 of a spill: abort, depth unchanged.
      err_en = 1; err_idx = 4;
      push_spill(7, 5); push(EV_ERR, 0, 0); push(EV_ACK, 0, 0);
      do_req("spill_err", 1, 0, 11, 7);
      err_en = 0;

      // Asynchronous reset while waiting for the first spill response.
      push_spill(7, 1);
      @(negedge clk);
      nest_req_i = 1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("pre_reset_state", {94'h0, busy_o, data_req_o}, {94'h0, 1'b1, 1'b0});
      rst_ni = 0;
      nest_req_i = 0;
      #1;
      chk_quiet("mid_reset", 0);
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1;
      #2;
      chk_quiet("after_abort", 0);
      repeat (3) @(negedge clk);
      #3;
      check("queue_empty", 96'(exp_q.size()), 96'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
